// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared types and constants for the debounced pin conditioner.
package sync_debounce_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_t;

   localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser that brings a raw asynchronous pin into the CK domain.
// It runs every CK regardless of any sampling tick, and SR loads RESET_VAL into every stage.
module sync_chain #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b1
) (
   input  logic CK,
   input  logic SR,
   input  logic D,
   output logic S
);

   logic [SYNC_STAGES-1:0] chain;

   // shift the raw pin through the synchroniser flops
   always_ff @(posedge CK) begin
      if (SR) chain <= {SYNC_STAGES{RESET_VAL}};
      else    chain <= {chain[SYNC_STAGES-2:0], D};
   end

   assign S = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronises a raw pin, qualifies level changes over DEBOUNCE_CYCLES
// CE samples, and produces a clean level Q plus one-cycle RISE/FALL pulses.
// Optional feature: define SYNC_DEBOUNCE_GLITCH_CNT_EN to add the saturating GLITCHES counter.
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 16,
   parameter logic        RESET_VAL       = 1'b1
) (
   input  logic                CK,
   input  logic                SR,
   input  logic                CE,
   input  logic                D,
   output logic                Q,
   output logic                RISE,
   output logic                FALL,
   output logic                BUSY
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] GLITCHES
`endif
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_debounce: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("sync_debounce: DEBOUNCE_CYCLES must be at least 1");
   end
   if (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_width
      $error("sync_debounce: DEBOUNCE_CYCLES does not fit in CNT_W bits");
   end

   // count value at which the next mismatching sample completes qualification
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic             commit;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL)
   ) u_sync (
      .CK (CK),
      .SR (SR),
      .D  (D),
      .S  (s)
   );

   // state register
   always_ff @(posedge CK) begin
      if (SR) state <= STABLE;
      else    state <= state_next;
   end

   // next-state, counter and commit decision
   always_comb begin
      state_next = state;
      count_next = count;
      commit     = 1'b0;
      if (CE) begin
         case (state)
            STABLE: begin
               if (s != Q) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     commit = 1'b1;
                  end else begin
                     state_next = CHECK;
                     count_next = CNT_W'(1);
                  end
               end
            end
            CHECK: begin
               if (s == Q) begin
                  state_next = STABLE;
                  count_next = '0;
               end else if (count == LAST) begin
                  commit     = 1'b1;
                  state_next = STABLE;
                  count_next = '0;
               end else begin
                  count_next = count + CNT_W'(1);
               end
            end
            default: begin
               state_next = STABLE;
               count_next = '0;
            end
         endcase
      end
   end

   // output decode
   always_comb begin
      BUSY = (state == CHECK);
   end

   // qualification counter, committed level and edge pulses
   always_ff @(posedge CK) begin
      if (SR) begin
         count <= '0;
         Q     <= RESET_VAL;
         RISE  <= 1'b0;
         FALL  <= 1'b0;
      end else begin
         count <= count_next;
         RISE  <= commit & s;
         FALL  <= commit & ~s;
         if (commit) Q <= s;
      end
   end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic reject;
   assign reject = CE && (state == CHECK) && (s == Q);

   // saturating count of rejected glitches
   always_ff @(posedge CK) begin
      if (SR)                        GLITCHES <= '0;
      else if (reject && GLITCHES != '1) GLITCHES <= GLITCHES + GLITCH_W'(1);
   end
`endif

endmodule
